// File: rtl/wrr_lock_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin lock arbiter.
package wrr_lock_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    localparam int unsigned DefNumReq        = 4;
    localparam int unsigned DefWeightWidth   = 4;
    localparam int unsigned DefMaxLockCycles = 64;

    // ORing the indices of set bits gives the binary index for a one-hot input.
    function automatic int unsigned onehot2bin(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/wrr_lock_arbiter_if.sv
// Request/grant bundle between bus masters and the lock arbiter.
// timeout_o exists only when WRR_ARB_TIMEOUT_EN is defined.
interface wrr_lock_arbiter_if #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned WeightWidth = 4
);
    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0]             req_i;
    logic [NumReq*WeightWidth-1:0] weight_i;
    logic                          unlock_i;
    logic [NumReq-1:0]             grant_o;
    logic [IdxWidth-1:0]           grant_idx_o;
    logic                          grant_valid_o;
`ifdef WRR_ARB_TIMEOUT_EN
    logic                          timeout_o;

    modport master (
        output req_i, weight_i, unlock_i,
        input  grant_o, grant_idx_o, grant_valid_o, timeout_o
    );
    modport slave (
        input  req_i, weight_i, unlock_i,
        output grant_o, grant_idx_o, grant_valid_o, timeout_o
    );
`else
    modport master (
        output req_i, weight_i, unlock_i,
        input  grant_o, grant_idx_o, grant_valid_o
    );
    modport slave (
        input  req_i, weight_i, unlock_i,
        output grant_o, grant_idx_o, grant_valid_o
    );
`endif

endinterface

// File: rtl/wrr_lock_arbiter_pick.sv
// Combinational rotating pick: first set request at or above the pointer, with wrap-around.
module wrr_lock_arbiter_pick
    import wrr_lock_arbiter_pkg::*;
#(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned IdxWidth = 2
) (
    input  logic [NumReq-1:0]   req,
    input  logic [NumReq-1:0]   ptr_oh,
    output logic [NumReq-1:0]   win_oh,
    output logic [IdxWidth-1:0] win_idx
);

    logic [2*NumReq-1:0] req_dbl;
    logic [2*NumReq-1:0] masked;

    // Subtracting the pointer clears the lowest request at/above it in the doubled
    // vector; the AND-NOT isolates exactly that bit, and the halves fold the wrap.
    assign req_dbl = {req, req};
    assign masked  = req_dbl & ~(req_dbl - {{NumReq{1'b0}}, ptr_oh});
    assign win_oh  = masked[NumReq-1:0] | masked[2*NumReq-1:NumReq];
    assign win_idx = IdxWidth'(onehot2bin(32'(win_oh)));

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter that locks each grant until the owner unlocks.
// Optional watchdog release enabled by defining WRR_ARB_TIMEOUT_EN.
//
//   state      | meaning
//   ARB_IDLE   | no owner; arbitrates every cycle
//   ARB_LOCKED | grant held; re-arbitrates only on unlock (or watchdog)
module wrr_lock_arbiter
    import wrr_lock_arbiter_pkg::*;
#(
    parameter int unsigned NumReq        = DefNumReq,
    parameter int unsigned WeightWidth   = DefWeightWidth,
    parameter int unsigned MaxLockCycles = DefMaxLockCycles
) (
    input logic               clk,
    input logic               rst_n,
    wrr_lock_arbiter_if.slave bus
);

    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    if (NumReq < 2 || MaxLockCycles < 1) begin : g_bad_params
        $error("wrr_lock_arbiter: NumReq must be >= 2 and MaxLockCycles >= 1");
    end

    arb_state_e           state_q, state_d;
    logic [NumReq-1:0]    grant_q, grant_d;
    logic [IdxWidth-1:0]  ptr_q, ptr_d;
    logic [WeightWidth-1:0] credit_q, credit_d;

    logic [NumReq-1:0]      ptr_oh;
    logic [NumReq-1:0]      win_oh;
    logic [IdxWidth-1:0]    win_idx;
    logic [IdxWidth-1:0]    nxt_idx;
    logic [WeightWidth-1:0] w_win;
    logic [WeightWidth-1:0] w_nxt;
    logic                   timeout_w;
    logic                   release_w;
    logic                   arb_en;
    logic                   load;

    assign ptr_oh = NumReq'(1) << ptr_q;

    wrr_lock_arbiter_pick #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .req     (bus.req_i),
        .ptr_oh  (ptr_oh),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    assign nxt_idx = (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + 1'b1;
    assign w_win   = bus.weight_i[int'(win_idx)*WeightWidth +: WeightWidth];
    assign w_nxt   = bus.weight_i[int'(nxt_idx)*WeightWidth +: WeightWidth];

    assign release_w = bus.unlock_i || timeout_w;
    assign arb_en    = (state_q == ARB_IDLE) || release_w;
    assign load      = arb_en && (|bus.req_i);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        if (arb_en) begin
            if (|bus.req_i) begin
                state_d = ARB_LOCKED;
                grant_d = win_oh;
                if (win_idx == ptr_q) begin
                    if (credit_q != '0) begin
                        credit_d = credit_q - 1'b1;
                    end else begin
                        ptr_d    = nxt_idx;
                        credit_d = w_nxt;
                    end
                // Skipping the pointer holder forfeits whatever credit it had left.
                end else if (w_win == '0) begin
                    ptr_d    = nxt_idx;
                    credit_d = w_nxt;
                end else begin
                    ptr_d    = win_idx;
                    credit_d = w_win - 1'b1;
                end
            end else begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            credit_q <= bus.weight_i[WeightWidth-1:0];
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

`ifdef WRR_ARB_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(MaxLockCycles + 1);

    // Holds the 1-based index of the current LOCKED cycle; 0 outside a session.
    logic [CntWidth-1:0] lock_cnt_q;

    assign timeout_w = (state_q == ARB_LOCKED) && !bus.unlock_i &&
                       (lock_cnt_q == CntWidth'(MaxLockCycles));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
        end else if (load) begin
            lock_cnt_q <= CntWidth'(1);
        end else if (state_q == ARB_LOCKED && !release_w) begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
        end else begin
            lock_cnt_q <= '0;
        end
    end

    assign bus.timeout_o = timeout_w;
`else
    assign timeout_w = 1'b0;
`endif

    assign bus.grant_o       = grant_q;
    assign bus.grant_valid_o = |grant_q;
    assign bus.grant_idx_o   = IdxWidth'(onehot2bin(32'(grant_q)));

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Scoreboard bench for wrr_lock_arbiter; watchdog scenario runs when WRR_ARB_TIMEOUT_EN is defined.
module tb_wrr_lock_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned WW = 4;
`ifdef WRR_ARB_TIMEOUT_EN
    localparam int unsigned MLC = 8;
`else
    localparam int unsigned MLC = 64;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wrr_lock_arbiter_if #(.NumReq(NR), .WeightWidth(WW)) bus ();

    wrr_lock_arbiter #(
        .NumReq        (NR),
        .WeightWidth   (WW),
        .MaxLockCycles (MLC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] grant;
        logic       to;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic set_w(input logic [3:0] w3, input logic [3:0] w2,
                         input logic [3:0] w1, input logic [3:0] w0);
        bus.weight_i = {w3, w2, w1, w0};
    endtask

    // Drive one cycle of stimulus, queue the grant expected after the edge, then compare.
    task automatic step(input logic rb, input logic [3:0] r, input logic u,
                        input logic [3:0] eg, input logic eto, input string tag);
        exp_t e;
        rst_n        = rb;
        bus.req_i    = r;
        bus.unlock_i = u;
        e.grant = eg;
        e.to    = eto;
        e.tag   = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq({e.tag, ".grant"}, 32'(bus.grant_o), 32'(e.grant));
        check_eq({e.tag, ".idx"},   32'(bus.grant_idx_o), 32'(idx_of(e.grant)));
        check_eq({e.tag, ".valid"}, 32'(bus.grant_valid_o), 32'(|e.grant));
`ifdef WRR_ARB_TIMEOUT_EN
        check_eq({e.tag, ".timeout"}, 32'(bus.timeout_o), 32'(e.to));
`endif
    endtask

    task automatic do_reset(input string tag);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, tag);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, tag);
    endtask

    logic [3:0] t2_exp [7];

    initial begin
        bus.req_i    = '0;
        bus.unlock_i = 1'b0;
        bus.weight_i = '0;

        // Plain round-robin with back-to-back handover.
        set_w(4'd0, 4'd0, 4'd0, 4'd0);
        do_reset("t1_rst");
        step(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, "t1_g0");
        step(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b0, "t1_g1");
        step(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b0, "t1_g2");
        step(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b0, "t1_g3");
        step(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, "t1_g0b");
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "t1_idle");

        // Weight 2 on requester 0 gives it three consecutive sessions.
        set_w(4'd0, 4'd0, 4'd0, 4'd2);
        do_reset("t2_rst");
        t2_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        step(1'b1, 4'b0011, 1'b0, 4'b0001, 1'b0, "t2_s0");
        for (int i = 0; i < 7; i++)
            step(1'b1, 4'b0011, 1'b1, t2_exp[i], 1'b0, $sformatf("t2_s%0d", i + 1));
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "t2_idle");

        // Grant held while LOCKED even after the owner drops its request.
        set_w(4'd0, 4'd0, 4'd0, 4'd0);
        do_reset("t3_rst");
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, "t3_g2");
        step(1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0, "t3_hold_a");
        step(1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0, "t3_hold_b");
        step(1'b1, 4'b0001, 1'b0, 4'b0100, 1'b0, "t3_ignore_req");
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "t3_unlock");
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "t3_unlock_idle");
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, "t3_idle");

        // Skip to a weighted requester, then the pointer moves past it.
        set_w(4'd0, 4'd1, 4'd0, 4'd0);
        do_reset("t4_rst");
        step(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, "t4_g0");
        step(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, "t4_g2a");
        step(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, "t4_g2b");
        step(1'b1, 4'b1001, 1'b1, 4'b1000, 1'b0, "t4_g3");
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "t4_idle");

        // Reset mid-session beats a simultaneous unlock and returns ptr to 0.
        set_w(4'd0, 4'd0, 4'd0, 4'd0);
        do_reset("t5_rst");
        step(1'b1, 4'b1000, 1'b0, 4'b1000, 1'b0, "t5_g3");
        step(1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, "t5_rst_mid");
        step(1'b1, 4'b1000, 1'b0, 4'b1000, 1'b0, "t5_g3_again");
        step(1'b1, 4'b1001, 1'b1, 4'b0001, 1'b0, "t5_g0");
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "t5_idle");
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, "t5_g2");
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, "t5_rst_ptr");
        step(1'b1, 4'b1001, 1'b0, 4'b0001, 1'b0, "t5_ptr0");
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "t5_idle_b");

`ifdef WRR_ARB_TIMEOUT_EN
        // Watchdog forces a release on the 8th LOCKED cycle.
        set_w(4'd0, 4'd0, 4'd0, 4'd0);
        do_reset("t6_rst");
        step(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, "t6_c1");
        for (int k = 2; k < 8; k++)
            step(1'b1, 4'b0100, 1'b0, 4'b0010, 1'b0, $sformatf("t6_c%0d", k));
        step(1'b1, 4'b0100, 1'b0, 4'b0010, 1'b1, "t6_c8");
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, "t6_g2");
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "t6_idle");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
